gshare_predictor: RTL

Parametrised global-history branch predictor, the successor to the per-address 2-bit counter table in the fetch stage. It holds a table of saturating counters of configurable width, indexed by instruction-address bits XOR a global history register (GHR). The GHR is updated speculatively at prediction time and repaired on misprediction. Fetch queries it combinationally; the ROB/branch unit trains it on branch resolve.

---
 rtl/gshare_predictor.sv | 84 ++++++++
 1 files changed

// File: rtl/gshare_predictor.sv
// Global-history branch predictor: saturating counters indexed by
// address XOR a speculatively updated, mispredict-repaired GHR.
module gshare_predictor #(
  parameter int INDEX_WIDTH = 6,
  parameter int HIST_WIDTH  = 6,
  parameter int CTR_WIDTH   = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   query_valid,
  input  logic [INDEX_WIDTH-1:0] query_addr,
  output logic                   prediction,
  output logic [HIST_WIDTH-1:0]  query_hist,
  input  logic                   update_valid,
  input  logic [INDEX_WIDTH-1:0] update_addr,
  input  logic [HIST_WIDTH-1:0]  update_hist,
  input  logic                   update_branch,
  input  logic                   update_mispredict
);

  localparam int ENTRIES = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = ~(CTR_MAX >> 1);

  logic [CTR_WIDTH-1:0]   ctr_q [ENTRIES];
  logic [HIST_WIDTH-1:0]  ghr_q;
  logic [INDEX_WIDTH-1:0] q_idx;
  logic [INDEX_WIDTH-1:0] u_idx;
  logic [CTR_WIDTH-1:0]   q_ctr;
  logic [CTR_WIDTH-1:0]   u_ctr;
  logic [CTR_WIDTH-1:0]   u_nxt;
  logic [HIST_WIDTH-1:0]  q_next;
  logic [HIST_WIDTH-1:0]  u_next;

  assign q_idx = query_addr ^ INDEX_WIDTH'(ghr_q);
  assign u_idx = update_addr ^ INDEX_WIDTH'(update_hist);

  assign q_ctr      = ctr_q[q_idx];
  assign u_ctr      = ctr_q[u_idx];
  assign prediction = q_ctr[CTR_WIDTH-1];
  assign query_hist = ghr_q;

  always_comb begin
    u_nxt = u_ctr;
    unique case (1'b1)
      update_branch && (u_ctr != CTR_MAX):
        u_nxt = u_ctr + CTR_WIDTH'(1);
      !update_branch && (u_ctr != '0):
        u_nxt = u_ctr - CTR_WIDTH'(1);
      default:
        u_nxt = u_ctr;
    endcase
  end

  // a 1-bit history has nothing to shift; it is just the new outcome
  if (HIST_WIDTH == 1) begin : g_h1
    assign q_next = prediction;
    assign u_next = update_branch;
  end else begin : g_hn
    assign q_next = {ghr_q[HIST_WIDTH-2:0], prediction};
    assign u_next = {update_hist[HIST_WIDTH-2:0], update_branch};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ghr_q <= '0;
    end else if (update_valid && update_mispredict) begin
      ghr_q <= u_next;
    end else if (query_valid) begin
      ghr_q <= q_next;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (update_valid) begin
      ctr_q[u_idx] <= u_nxt;
    end
  end

endmodule
